// File: rtl/toy_seq_controller.sv
// Multi-cycle sequencer for the toy CPU: fetch, decode, optional data-memory
// access and execute, with memory handshake stalls bounded by TIMEOUT.
module toy_seq_controller #(
    parameter int OPW     = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           imem_ready,
    input  logic           dmem_ready,
    input  logic           flag_c,
    input  logic           flag_z,
    output logic           rd_imem,
    output logic           ir_load,
    output logic           pc_en,
    output logic [1:0]     src_pc,
    output logic [2:0]     alu_op,
    output logic           wr_t,
    output logic           wr_a,
    output logic           src_a,
    output logic           rd_dmem,
    output logic           wr_dmem,
    output logic           src_adr,
    output logic           src_data,
    output logic           halted,
    output logic           err_illegal,
    output logic           err_timeout
);
    typedef enum logic [2:0] {FETCH, DECODE, MEM_RD, MEM_WR, EXEC, HALT} state_t;

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    localparam logic [3:0] OP_JMP = 4'h0, OP_ADC = 4'h1, OP_XOR = 4'h2, OP_SBR = 4'h3;
    localparam logic [3:0] OP_ROR = 4'h4, OP_TAT = 4'h5, OP_OR  = 4'h6, OP_ILL = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8, OP_LDC = 4'h9, OP_BCC = 4'hA, OP_BNE = 4'hB;
    localparam logic [3:0] OP_LDI = 4'hC, OP_STT = 4'hD, OP_LDA = 4'hE, OP_STA = 4'hF;

    state_t         state, nxt;
    logic [OPW-1:0] op;
    logic [CW-1:0]  cnt;
    logic [31:0]    op_ext;
    logic [3:0]     op4;
    logic           op_bad, cls_rd, cls_wr, is_wr_a, is_src_a, taken;
    logic [2:0]     alu_sel;
    logic           fetch_hit, waiting, ready_now, timed_out;

    assign op_ext   = 32'(op);
    assign op4      = op_ext[3:0];
    assign op_bad   = (op_ext > 32'd15) || (op4 == OP_ILL);
    assign is_wr_a  = op4 inside {OP_ADC, OP_XOR, OP_SBR, OP_ROR, OP_OR, OP_AND, OP_LDC, OP_LDI, OP_LDA};
    assign is_src_a = op4 inside {OP_LDC, OP_LDI, OP_LDA};
    assign taken    = (op4 == OP_JMP) || (op4 == OP_BCC && !flag_c) || (op4 == OP_BNE && !flag_z);

    always_comb begin
        cls_rd  = 1'b0;
        cls_wr  = 1'b0;
        alu_sel = 3'b000;
        case (op4)
            OP_ADC, OP_XOR, OP_SBR, OP_OR, OP_AND, OP_LDC, OP_LDI, OP_LDA: cls_rd = 1'b1;
            OP_STT, OP_STA: cls_wr = 1'b1;
            default: ;
        endcase
        case (op4)
            OP_SBR:  alu_sel = 3'b001;
            OP_ROR:  alu_sel = 3'b100;
            OP_XOR:  alu_sel = 3'b101;
            OP_OR:   alu_sel = 3'b110;
            OP_AND:  alu_sel = 3'b111;
            default: alu_sel = 3'b000;
        endcase
    end

    // rd_imem is low for the single cycle after reset release; FETCH only
    // accepts a word or counts stall cycles once the request is out.
    assign fetch_hit = (state == FETCH) && rd_imem && imem_ready;
    assign waiting   = ((state == FETCH) && rd_imem) || (state == MEM_RD) || (state == MEM_WR);
    assign ready_now = (state == FETCH) ? imem_ready : dmem_ready;
    assign timed_out = (TIMEOUT > 0) && waiting && !ready_now && (cnt == CNT_LAST);

    assign ir_load = fetch_hit;
    assign src_pc  = (state == EXEC && taken) ? 2'b01 : 2'b00;

    always_comb begin
        nxt = state;
        case (state)
            FETCH:  if (fetch_hit) nxt = DECODE;
                    else if (timed_out) nxt = HALT;
            DECODE: if (op_bad) nxt = HALT;
                    else if (cls_rd) nxt = MEM_RD;
                    else if (cls_wr) nxt = MEM_WR;
                    else nxt = EXEC;
            MEM_RD, MEM_WR: if (dmem_ready) nxt = EXEC;
                            else if (timed_out) nxt = HALT;
            EXEC:   nxt = FETCH;
            HALT:   nxt = HALT;
            default: nxt = HALT;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            op          <= '0;
            cnt         <= '0;
            rd_imem     <= 1'b0;
            pc_en       <= 1'b0;
            alu_op      <= 3'b000;
            wr_t        <= 1'b0;
            wr_a        <= 1'b0;
            src_a       <= 1'b0;
            rd_dmem     <= 1'b0;
            wr_dmem     <= 1'b0;
            src_adr     <= 1'b0;
            src_data    <= 1'b0;
            halted      <= 1'b0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= nxt;
            if (fetch_hit)
                op <= opcode;
            if (nxt != state)
                cnt <= '0;
            else if (waiting && !ready_now && cnt != CNT_MAX)
                cnt <= cnt + CW'(1);
            if (state == DECODE && op_bad)
                err_illegal <= 1'b1;
            if (timed_out)
                err_timeout <= 1'b1;
            rd_imem  <= (nxt == FETCH);
            rd_dmem  <= (nxt == MEM_RD);
            wr_dmem  <= (nxt == MEM_WR);
            src_adr  <= (nxt == MEM_RD && op4 == OP_LDI) || (nxt == MEM_WR && op4 == OP_STT);
            src_data <= (nxt == MEM_WR && op4 == OP_STT);
            alu_op   <= (nxt == MEM_RD || nxt == EXEC) ? alu_sel : 3'b000;
            pc_en    <= (nxt == EXEC);
            wr_a     <= (nxt == EXEC) && is_wr_a;
            src_a    <= (nxt == EXEC) && is_src_a;
            wr_t     <= (nxt == EXEC) && (op4 == OP_TAT);
            halted   <= (nxt == HALT);
        end
    end
endmodule

// File: tb/tb_toy_seq_controller.sv
// Self-checking bench for toy_seq_controller: directed scenarios plus random
// instruction streams checked against a table-driven per-cycle model.
module tb_toy_seq_controller;
    localparam int OPW     = 4;
    localparam int TIMEOUT = 3;
    localparam int P_FETCH = 0, P_DEC = 1, P_MRD = 2, P_MWR = 3, P_EXEC = 4, P_HALT = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [OPW-1:0] opcode = '0;
    logic           imem_ready = 1'b0, dmem_ready = 1'b0, flag_c = 1'b0, flag_z = 1'b0;
    logic           rd_imem, ir_load, pc_en, wr_t, wr_a, src_a, rd_dmem, wr_dmem;
    logic           src_adr, src_data, halted, err_illegal, err_timeout;
    logic [1:0]     src_pc;
    logic [2:0]     alu_op;
    logic [17:0]    obs, exp_v;
    int             checks = 0;
    int             errors = 0;

    toy_seq_controller #(.OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .flag_c(flag_c), .flag_z(flag_z),
        .rd_imem(rd_imem), .ir_load(ir_load), .pc_en(pc_en), .src_pc(src_pc),
        .alu_op(alu_op), .wr_t(wr_t), .wr_a(wr_a), .src_a(src_a),
        .rd_dmem(rd_dmem), .wr_dmem(wr_dmem), .src_adr(src_adr), .src_data(src_data),
        .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    assign obs = {rd_imem, ir_load, pc_en, src_pc, alu_op, wr_t, wr_a, src_a,
                  rd_dmem, wr_dmem, src_adr, src_data, halted, err_illegal, err_timeout};

    // 0 illegal, 1 memory read, 2 memory write, 3 register/branch
    function automatic int op_class(input int op);
        if (op == 7) return 0;
        if (op inside {1, 2, 3, 6, 8, 9, 12, 14}) return 1;
        if (op inside {13, 15}) return 2;
        return 3;
    endfunction

    function automatic logic [2:0] alu_of(input int op);
        case (op)
            3: return 3'b001;
            4: return 3'b100;
            2: return 3'b101;
            6: return 3'b110;
            8: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [17:0] ev(input int ph, input int op, input bit ir,
                                       input bit fc, input bit fz, input bit ei, input bit et);
        logic rdi, irl, pce, wt, wa, sa, rdd, wrd, sadr, sdat, hl;
        logic [1:0] spc;
        logic [2:0] alu;
        {rdi, irl, pce, wt, wa, sa, rdd, wrd, sadr, sdat, hl} = '0;
        spc = 2'b00;
        alu = 3'b000;
        case (ph)
            P_FETCH: begin rdi = 1'b1; irl = ir; end
            P_MRD:   begin rdd = 1'b1; sadr = (op == 12); alu = alu_of(op); end
            P_MWR:   begin wrd = 1'b1; sadr = (op == 13); sdat = (op == 13); end
            P_EXEC: begin
                pce = 1'b1;
                alu = alu_of(op);
                wa  = op inside {1, 2, 3, 4, 6, 8, 9, 12, 14};
                sa  = op inside {9, 12, 14};
                wt  = (op == 5);
                if (op == 0 || (op == 10 && !fc) || (op == 11 && !fz)) spc = 2'b01;
            end
            P_HALT: hl = 1'b1;
            default: ;
        endcase
        return {rdi, irl, pce, spc, alu, wt, wa, sa, rdd, wrd, sadr, sdat, hl, ei, et};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first FETCH cycle with rd_imem up.
    task automatic do_reset();
        rst = 1'b1;
        {imem_ready, dmem_ready, flag_c, flag_z} = '0;
        opcode = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    // One instruction from FETCH back to the next FETCH, fw/mw stall cycles.
    task automatic run_instr(input int op, input int fw, input int mw, input bit fc, input bit fz);
        int cls;
        cls = op_class(op);
        for (int i = 0; i <= fw; i++) begin
            imem_ready = (i == fw);
            opcode     = (i == fw) ? 4'(op) : 4'($urandom);
            dmem_ready = 1'($urandom);
            {flag_c, flag_z} = 2'($urandom);
            @(negedge clk);
            exp_v = ev(P_FETCH, op, i == fw, 0, 0, 0, 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL fetch op=%0d wait=%0d: got %b want %b", op, i, obs, exp_v);
            end
            next_cycle();
        end
        imem_ready = 1'($urandom);
        opcode     = 4'($urandom);
        @(negedge clk);
        exp_v = ev(P_DEC, op, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL decode op=%0d: got %b want %b", op, obs, exp_v);
        end
        next_cycle();
        if (cls == 1 || cls == 2) begin
            for (int j = 0; j <= mw; j++) begin
                dmem_ready = (j == mw);
                imem_ready = 1'($urandom);
                @(negedge clk);
                exp_v = ev((cls == 1) ? P_MRD : P_MWR, op, 0, 0, 0, 0, 0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL mem op=%0d wait=%0d: got %b want %b", op, j, obs, exp_v);
                end
                next_cycle();
            end
        end
        flag_c     = fc;
        flag_z     = fz;
        dmem_ready = 1'($urandom);
        imem_ready = 1'b0;
        @(negedge clk);
        exp_v = ev(P_EXEC, op, 0, fc, fz, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL exec op=%0d c=%0d z=%0d: got %b want %b", op, fc, fz, obs, exp_v);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        do_reset();
        rst        = 1'b1;
        imem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== 18'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b want 0", obs);
        end
        imem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 18'd0) begin
            errors++;
            $display("FAIL reset_release: got %b want 0", obs);
        end
        next_cycle();
        exp_v = ev(P_FETCH, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_first_fetch: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_adc_timing();
        int ph[5] = '{P_FETCH, P_DEC, P_MRD, P_EXEC, P_FETCH};
        do_reset();
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        opcode     = 4'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_v = ev(ph[c], 1, ph[c] == P_FETCH, 0, 0, 0, 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL adc_cycle%0d: got %b want %b", c, obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        do_reset();
        run_instr(11, 0, 0, 1'b0, 1'b0);
        run_instr(11, 1, 0, 1'b1, 1'b1);
        run_instr(10, 0, 0, 1'b0, 1'b1);
        run_instr(10, 2, 0, 1'b1, 1'b0);
        run_instr(0, 0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_illegal();
        do_reset();
        imem_ready = 1'b1;
        opcode     = 4'd7;
        @(negedge clk);
        exp_v = ev(P_FETCH, 7, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL illegal_fetch: got %b want %b", obs, exp_v);
        end
        next_cycle();
        imem_ready = 1'b0;
        @(negedge clk);
        exp_v = ev(P_DEC, 7, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL illegal_decode: got %b want %b", obs, exp_v);
        end
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            imem_ready = k[0];
            opcode     = 4'($urandom);
            dmem_ready = 1'($urandom);
            @(negedge clk);
            exp_v = ev(P_HALT, 7, 0, 0, 0, 1, 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL illegal_halt%0d: got %b want %b", k, obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        // data-memory stall runs out
        do_reset();
        imem_ready = 1'b1;
        opcode     = 4'd14;
        next_cycle();
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        next_cycle();
        for (int k = 0; k < TIMEOUT + 2; k++) begin
            @(negedge clk);
            exp_v = (k < TIMEOUT) ? ev(P_MRD, 14, 0, 0, 0, 0, 0) : ev(P_HALT, 14, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL dmem_timeout%0d: got %b want %b", k, obs, exp_v);
            end
            next_cycle();
        end
        // ready in the last allowed cycle wins
        do_reset();
        run_instr(14, 0, TIMEOUT - 1, 1'b0, 1'b0);
        run_instr(4, TIMEOUT - 1, 0, 1'b0, 1'b0);
        // instruction-memory stall runs out
        do_reset();
        for (int k = 0; k < TIMEOUT + 2; k++) begin
            @(negedge clk);
            exp_v = (k < TIMEOUT) ? ev(P_FETCH, 0, 0, 0, 0, 0, 0) : ev(P_HALT, 0, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL imem_timeout%0d: got %b want %b", k, obs, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_store();
        do_reset();
        run_instr(13, 0, 2, 1'b0, 1'b0);
        run_instr(15, 1, 1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        imem_ready = 1'b1;
        opcode     = 4'd13;
        next_cycle();
        imem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        exp_v = ev(P_MWR, 13, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL mid_write_pre: got %b want %b", obs, exp_v);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 18'd0) begin
            errors++;
            $display("FAIL mid_write_reset: got %b want 0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        run_instr(9, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int op = 0; op < 16; op++)
            if (op != 7) run_instr(op, 0, 0, 1'($urandom), 1'($urandom));
    endtask

    task automatic test_random();
        int op;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            do op = $urandom_range(15, 0); while (op == 7);
            run_instr(op, $urandom_range(TIMEOUT - 1, 0), $urandom_range(TIMEOUT - 1, 0),
                      1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_adc_timing();
        test_branch();
        test_illegal();
        test_timeout();
        test_store();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
